// File: rtl/fetch_instruction_pkg.sv
// Shared widths, reset PC and FSM encodings for the fetch stage.
// Instance parameters of fetch_instruction default to these values.
package fetch_instruction_pkg;
    localparam int FI_WORD     = 32;
    localparam int FI_ADDR     = 16;
    localparam int FI_W_BRID   = 3;
    localparam int FI_FQ_DEPTH = 2;
    localparam int FI_RESET_PC = 0;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        REDIR = 2'd2
    } fetch_state_e;
endpackage

// File: rtl/fetch_instruction_queue.sv
// fetch_queue: synchronous FIFO of fetched {brid, pc, inst} entries, flush beats push.
// Latency: a pushed entry is visible at pop_dat the cycle after the push.
// Backpressure: none internal; the producer must respect full/count.
module fetch_queue #(
    parameter int W     = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_dat,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign pop_dat = mem[rd_ptr];
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
endmodule

// File: rtl/fetch_instruction.sv
// fetch_instruction: PC owner and imem requester feeding decode; optional perf counters under FETCH_PERF_EN.
// Latency: word visible at v_o in the imem return cycle (BOOT/REDIR, issue, return).
// Backpressure: stall_i fills the fetch queue, then issue stops; nothing dropped or duplicated.
module fetch_instruction
    import fetch_instruction_pkg::*;
#(
    parameter int WORD     = FI_WORD,
    parameter int ADDR     = FI_ADDR,
    parameter int W_BRID   = FI_W_BRID,
    parameter int FQ_DEPTH = FI_FQ_DEPTH,
    parameter int RESET_PC = FI_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_o,
    output logic [ADDR-1:0]   imem_addr_o,
    input  logic [WORD-1:0]   imem_data_i,
    input  logic              branch_i,
    input  logic [ADDR-1:0]   branch_pc_i,
    input  logic              stall_i,
    output logic              v_o,
    output logic [WORD-1:0]   inst_o,
    output logic [ADDR-1:0]   pc_o,
    output logic [W_BRID-1:0] brid_o
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetched_o,
    output logic [31:0]       perf_bubble_o
`endif
);
    localparam int CW = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [W_BRID-1:0] brid;
        logic [ADDR-1:0]   pc;
        logic [WORD-1:0]   inst;
    } entry_t;

    fetch_state_e      state_r, state_nxt;
    logic [ADDR-1:0]   pc_r, ret_pc_r;
    logic [W_BRID-1:0] brid_r, ret_brid_r;
    logic              inflight_r;
    entry_t            ret_ent, q_head, head, last_r;
    logic [CW-1:0]     q_count;
    logic              q_empty, q_full, q_push, q_pop;
    logic              issue, head_vld, take;

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            BOOT:    state_nxt = RUN;
            RUN:     state_nxt = RUN;
            REDIR:   state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
        if (branch_i) state_nxt = REDIR;
    end

    // Issue only when the returning word is guaranteed a slot next cycle.
    assign issue = (state_r == RUN) && !branch_i &&
                   ((32'(q_count) + 32'(inflight_r) + 32'd1) <= 32'(FQ_DEPTH));

    assign imem_req_o  = issue;
    assign imem_addr_o = pc_r;

    // An empty queue lets the returning word go straight to decode.
    assign ret_ent  = '{brid: ret_brid_r, pc: ret_pc_r, inst: imem_data_i};
    assign head_vld = !q_empty || inflight_r;
    assign head     = q_empty ? ret_ent : q_head;
    assign v_o      = head_vld && !branch_i;
    assign take     = v_o && !stall_i;
    assign q_pop    = take && !q_empty;
    assign q_push   = inflight_r && !(q_empty && take);

    assign inst_o = head_vld ? head.inst : last_r.inst;
    assign pc_o   = head_vld ? head.pc   : last_r.pc;
    assign brid_o = head_vld ? head.brid : last_r.brid;

    fetch_queue #(
        .W     ($bits(entry_t)),
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .pop      (q_pop),
        .flush    (branch_i),
        .push_dat (ret_ent),
        .pop_dat  (q_head),
        .count    (q_count),
        .empty    (q_empty),
        .full     (q_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= BOOT;
            pc_r       <= ADDR'(RESET_PC);
            brid_r     <= '0;
            inflight_r <= 1'b0;
            ret_pc_r   <= '0;
            ret_brid_r <= '0;
            last_r     <= '0;
        end else begin
            state_r    <= state_nxt;
            inflight_r <= issue;
            if (head_vld) last_r <= head;
            if (branch_i) begin
                pc_r   <= branch_pc_i;
                brid_r <= brid_r + W_BRID'(1);
            end else if (issue) begin
                pc_r       <= pc_r + ADDR'(1);
                ret_pc_r   <= pc_r;
                ret_brid_r <= brid_r;
            end
        end
    end

    assert property (@(posedge clk) disable iff (reset)
        !(q_push && q_full && !q_pop && !branch_i));

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_o <= '0;
            perf_bubble_o  <= '0;
        end else begin
            if (take && perf_fetched_o != '1)
                perf_fetched_o <= perf_fetched_o + 32'd1;
            if (state_r == RUN && !v_o && !stall_i && perf_bubble_o != '1)
                perf_bubble_o <= perf_bubble_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_fetch_instruction.sv
// Directed bench for fetch_instruction: imem model returns 0x1000+addr one cycle
// after a request; a scoreboard of expected {pc, brid} is checked at every delivery.
module tb_fetch_instruction;
    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic [31:0] imem_data_i = 32'h0;
    logic        branch_i;
    logic [15:0] branch_pc_i;
    logic        stall_i;
    logic        v_o;
    logic [31:0] inst_o;
    logic [15:0] pc_o;
    logic [2:0]  brid_o;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_o;
    logic [31:0] perf_bubble_o;
`endif

    fetch_instruction dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_data_i (imem_data_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .stall_i     (stall_i),
        .v_o         (v_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .brid_o      (brid_o)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched_o (perf_fetched_o),
        .perf_bubble_o  (perf_bubble_o)
`endif
    );

    always #10 clk = ~clk;

    always @(posedge clk)
        imem_data_i <= imem_req_o ? (32'h1000 + {16'h0, imem_addr_o}) : 32'hDEADBEEF;

    typedef struct {
        logic [15:0] pc;
        logic [2:0]  brid;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   first_v = 0;
    int   n_deliv = 0;
    int   d0;
    logic [2:0] exp_brid = 3'd0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] start, input logic [2:0] b);
        logic [15:0] p;
        p = start;
        sb.delete();
        for (int i = 0; i < 64; i++) begin
            sb.push_back('{pc: p, brid: b});
            p = p + 16'd1;
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (v_o === 1'b1 && first_v == 0) first_v = cyc;
        if (v_o === 1'b1 && stall_i === 1'b0) begin
            n_deliv++;
            chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("deliv_pc", pc_o, e.pc);
                chk("deliv_inst", inst_o, 32'h1000 + {16'h0, e.pc});
                chk("deliv_brid", brid_o, e.brid);
            end
        end
    endtask

    task automatic tick();
        #4;
        monitor();
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic branch_to(input logic [15:0] addr);
        branch_i    = 1'b1;
        branch_pc_i = addr;
        exp_brid    = exp_brid + 3'd1;
        fill(addr, exp_brid);
        #2 chk("branch_v_low", v_o, 1'b0);
        tick();
        branch_i = 1'b0;
    endtask

    task automatic expect_redirect(input logic [15:0] addr, input logic [2:0] b);
        for (int i = 0; i < 2; i++) begin
            #2 chk("redir_v_low", v_o, 1'b0);
            tick();
        end
        #2;
        chk("redir_v", v_o, 1'b1);
        chk("redir_pc", pc_o, addr);
        chk("redir_brid", brid_o, b);
        tick();
    endtask

    initial begin
        reset = 1'b1; branch_i = 1'b0; branch_pc_i = 16'h0; stall_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_v", v_o, 1'b0);
        chk("rst_req", imem_req_o, 1'b0);
        chk("rst_inst", inst_o, 32'h0);
        chk("rst_pc", pc_o, 16'h0);
        chk("rst_brid", brid_o, 3'h0);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetched", perf_fetched_o, 32'h0);
        chk("rst_perf_bubble", perf_bubble_o, 32'h0);
`endif

        // Stream from reset: first word in the third cycle, then one per cycle.
        fill(16'h0, 3'd0);
        exp_brid = 3'd0;
        reset = 1'b0; cyc = 1; first_v = 0; n_deliv = 0;
        run(12);
        chk("first_v_cycle", first_v, 3);
        chk("stream_count", n_deliv, 10);

        // Decode stall: head held, issue stops once the queue is full.
        stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall_v", v_o, 1'b1);
            chk("stall_head_pc", pc_o, sb[0].pc);
            if (i > 0) chk("stall_req", imem_req_o, 1'b0);
            tick();
        end
        stall_i = 1'b0;
        d0 = n_deliv;
        run(6);
        chk("resume_count", n_deliv - d0, 6);

        // Single redirect.
        branch_to(16'h0040);
        expect_redirect(16'h0040, 3'd1);
        run(5);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_s123", perf_fetched_o, n_deliv);
        chk("perf_bubble_s123", perf_bubble_o, 3);
`endif

        // Reset while full and stalled.
        stall_i = 1'b1;
        run(4);
        reset = 1'b1;
        tick();
        reset = 1'b0; stall_i = 1'b0; cyc = 1; first_v = 0; n_deliv = 0;
        #2;
        chk("mid_rst_v", v_o, 1'b0);
        chk("mid_rst_req", imem_req_o, 1'b0);
`ifdef FETCH_PERF_EN
        chk("mid_rst_perf_fetched", perf_fetched_o, 32'h0);
        chk("mid_rst_perf_bubble", perf_bubble_o, 32'h0);
`endif
        fill(16'h0, 3'd0);
        exp_brid = 3'd0;
        run(6);
        chk("restart_first_v", first_v, 3);

        // Back-to-back redirects: only the second target is delivered.
        branch_to(16'h0040);
        branch_to(16'h0080);
        expect_redirect(16'h0080, 3'd2);
        run(4);
`ifdef FETCH_PERF_EN
        chk("perf_fetched_s4", perf_fetched_o, n_deliv);
        chk("perf_bubble_s4", perf_bubble_o, 3);
`endif

        // Branch-epoch wrap 7 -> 0 and PC wrap 0xFFFF -> 0x0000.
        for (int i = 0; i < 5; i++) branch_to(16'h0100);
        branch_to(16'hFFFE);
        expect_redirect(16'hFFFE, 3'd0);
        d0 = n_deliv;
        run(4);
        chk("wrap_count", n_deliv - d0, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
